// File: rtl/seqgen_pkg.sv
// Shared types and seed values for the multi-sequence term generator.
// History registers hold t(n), t(n-1), t(n-2) after the start cycle.
package seqgen_pkg;

   typedef enum logic [2:0] {
      M_SQUARE = 3'd0,
      M_POW3   = 3'd1,
      M_TRI    = 3'd2,
      M_FIB    = 3'd3,
      M_PELL   = 3'd4,
      M_LUCAS  = 3'd5,
      M_PADOV  = 3'd6,
      M_SYLV   = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] seed_a(mode_e m);
      logic [31:0] v;
      v = 32'd0;
      unique case (m)
         M_POW3, M_FIB, M_PADOV: v = 32'd1;
         M_LUCAS, M_SYLV:        v = 32'd2;
         default:                v = 32'd0;
      endcase
      return v;
   endfunction

   // Seeds t(-1): chosen so the recurrence yields the listed index-1 term
   function automatic logic [31:0] seed_b(mode_e m);
      logic [31:0] v;
      v = 32'd0;
      unique case (m)
         M_PELL:  v = 32'd1;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] seed_c(mode_e m);
      logic [31:0] v;
      v = 32'd0;
      unique case (m)
         M_PADOV: v = 32'd1;
         default: v = 32'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/seqgen_multi_if.sv
// Control and output-stream bundle of the sequence generator.
// Master drives requests and ready; slave returns the term stream.
interface seqgen_multi_if #(
   parameter int WIDTH = 8,
   parameter int IDXW  = 8
);
   logic [2:0]       mode;
   logic             start;
   logic             clear;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [IDXW-1:0]  out_index;
   logic             overflow;
   logic             busy;

   modport master (
      output mode, start, clear, out_ready,
      input  out_valid, out_data, out_index, overflow, busy
   );

   modport slave (
      input  mode, start, clear, out_ready,
      output out_valid, out_data, out_index, overflow, busy
   );
endinterface

// File: rtl/seqgen_recur.sv
// Combinational next-term evaluator at 2*W precision.
// ovf_o flags an exact next term that does not fit in W bits.
module seqgen_recur
   import seqgen_pkg::*;
#(
   parameter int W = 8
) (
   input  mode_e          mode_i,
   input  logic           first_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   input  logic [W-1:0]   c_i,
   input  logic [W-1:0]   k_i,
   output logic [W-1:0]   nxt_o,
   output logic           ovf_o
);
   localparam int DW = 2 * W;
   localparam logic [DW-1:0] ONE = DW'(1);

   logic [DW-1:0] ea, eb, ec, ek, ex;

   assign ea = {{W{1'b0}}, a_i};
   assign eb = {{W{1'b0}}, b_i};
   assign ec = {{W{1'b0}}, c_i};
   assign ek = {{W{1'b0}}, k_i};

   always_comb begin
      ex = '0;
      unique case (mode_i)
         M_SQUARE: ex = ea + (ek << 1) + ONE;
         M_POW3:   ex = ea + (ea << 1);
         M_TRI:    ex = ea + ek + ONE;
         M_FIB:    ex = ea + eb;
         M_PELL:   ex = (ea << 1) + eb;
         // Lucas t(-1) is -1; the first step is fixed instead of seeded
         M_LUCAS:  ex = first_i ? ONE : ea + eb;
         M_PADOV:  ex = eb + ec;
         M_SYLV:   ex = ea * (ea - ONE) + ONE;
         default:  ex = '0;
      endcase
   end

   assign nxt_o = ex[W-1:0];
   assign ovf_o = |ex[DW-1:W];

endmodule

// File: rtl/seqgen_multi.sv
// Multi-sequence term generator with valid/ready output stream.
// SEQGEN_OVERFLOW_STOP_EN: stop in DONE on overflow instead of wrapping.
module seqgen_multi
   import seqgen_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDXW  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   seqgen_multi_if.slave bus
);
   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             ovf_q, ovf_d;
   logic             first_q, first_d;

   logic [WIDTH-1:0] nxt;
   logic             nxt_ovf;
   logic             fire;
   logic             adv;
   mode_e            req_mode;

   seqgen_recur #(.W(WIDTH)) u_recur (
      .mode_i  (mode_q),
      .first_i (first_q),
      .a_i     (a_q),
      .b_i     (b_q),
      .c_i     (c_q),
      .k_i     (k_q),
      .nxt_o   (nxt),
      .ovf_o   (nxt_ovf)
   );

   assign req_mode = mode_e'(bus.mode);
   assign fire     = (state_q == S_RUN) && bus.out_ready;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      k_d     = k_q;
      idx_d   = idx_q;
      ovf_d   = ovf_q;
      first_d = first_q;
      adv     = 1'b0;
      if (bus.clear) begin
         state_d = S_IDLE;
         mode_d  = M_SQUARE;
         a_d     = '0;
         b_d     = '0;
         c_d     = '0;
         k_d     = '0;
         idx_d   = '0;
         first_d = 1'b0;
      end else if (bus.start) begin
         state_d = S_RUN;
         mode_d  = req_mode;
         a_d     = WIDTH'(seed_a(req_mode));
         b_d     = WIDTH'(seed_b(req_mode));
         c_d     = WIDTH'(seed_c(req_mode));
         k_d     = '0;
         idx_d   = '0;
         ovf_d   = 1'b0;
         first_d = 1'b1;
      end else if (fire) begin
         adv = 1'b1;
`ifdef SEQGEN_OVERFLOW_STOP_EN
         if (nxt_ovf) begin
            adv     = 1'b0;
            state_d = S_DONE;
            ovf_d   = 1'b1;
         end
`else
         ovf_d = ovf_q | nxt_ovf;
`endif
      end
      if (adv) begin
         a_d     = nxt;
         b_d     = a_q;
         c_d     = b_q;
         k_d     = k_q + 1'b1;
         idx_d   = idx_q + 1'b1;
         first_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= M_SQUARE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         k_q     <= '0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
         first_q <= first_d;
      end
   end

   assign bus.out_valid = (state_q == S_RUN);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_data  = a_q;
   assign bus.out_index = idx_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: doc/seqgen_multi.md
SEQGEN_MULTI -- requirements
Module: seqgen_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning term width in bits (legal 4..32).
REQ-002 SHALL have parameter IDXW, default 8, meaning term-index counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port mode  input  3  sequence select: 0 squares, 1 powers of 3, 2 triangular, 3 Fibonacci, 4 Pell, 5 Lucas, 6 Padovan, 7 Sylvester.
REQ-006 SHALL have port start  input  1  single-cycle request to latch mode and begin at index 0.
REQ-007 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the current term.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index hold a valid term.
REQ-010 SHALL have port out_data  output  WIDTH  current term, mod 2^WIDTH.
REQ-011 SHALL have port out_index  output  IDXW  index n of current term.
REQ-012 SHALL have port overflow  output  1  sticky: some exact term since start exceeded 2^WIDTH-1.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE per REQ-022; DONE->RUN on start; any state->IDLE on clear.
REQ-015 SHALL, on start, latch mode, load index-0 seeds, clear overflow, and assert out_valid on the following cycle (1-cycle latency).
REQ-016 SHALL produce index-0.. terms: squares 0,1,4,9; pow3 1,3,9,27; triangular 0,1,3,6; Fibonacci 1,1,2,3; Pell 0,1,2,5; Lucas 2,1,3,4; Padovan 1,1,1,2,2,3; Sylvester 2,3,7,43.
REQ-017 SHALL advance exactly one term per cycle in which out_valid and out_ready are both high; no advance otherwise.
REQ-018 SHALL hold out_data and out_index stable while out_valid is high and out_ready is low.
REQ-019 SHALL compute squares and triangular incrementally (n^2+2n+1, T+n+1), not by multiplier on index.
REQ-020 SHALL evaluate each recurrence at full precision (2*WIDTH bits for Sylvester and pow3) and set overflow when the exact next term exceeds 2^WIDTH-1; internal history registers SHALL carry only the WIDTH-bit truncation.
REQ-021 SHALL wrap out_index from 2^IDXW-1 to 0 without affecting the sequence.
REQ-022 SHALL handle the overflowing advance per the Configuration section.
REQ-023 SHALL ignore mode changes except at the start cycle; start while in RUN SHALL restart at index 0.
REQ-024 SHALL give clear priority over start when both asserted in one cycle.
REQ-025 SHALL drive out_valid low in IDLE and DONE.

Reset
REQ-026 SHALL, when rst_n is low at a clock edge, enter IDLE with out_valid 0, out_data 0, out_index 0, overflow 0, busy 0, latched mode 0, regardless of current state.
REQ-027 SHALL give rst_n priority over clear and start; clear SHALL reach the same state except overflow retains its value until next start.

Configuration
REQ-028 SHALL, with SEQGEN_OVERFLOW_STOP_EN defined, on an overflowing advance enter DONE, set overflow, keep out_data/out_index at the last representable term.
REQ-029 SHALL, without SEQGEN_OVERFLOW_STOP_EN, stay in RUN, present the truncated term, set overflow, and never enter DONE.

Structure
REQ-030 SHALL place the mode enum, FSM state enum and per-mode seed constants in package seqgen_pkg.
REQ-031 SHALL implement next-term and overflow computation in combinational sub-module seqgen_recur, instantiated once.

Verification
REQ-032 SHALL cover: WIDTH=8, mode 3, out_ready=1 -> 1,1,2,3,...,233 at index 12; index 13 gives 121 + overflow (macro off) or DONE, out_valid 0, out_data 233 (macro on).
REQ-033 SHALL cover: mode 4, out_ready low 3 cycles at index 4 -> out_data 12, out_index 4 held; then 29 at index 5.
REQ-034 SHALL cover: mode 7 -> 2,3,7,43; index 4 gives 15 with overflow (macro off).
REQ-035 SHALL cover: mode 1 running, clear and start same cycle -> IDLE, out_valid 0 next cycle.
REQ-036 SHALL cover: rst_n low mid-run in mode 6 at index 7 -> all outputs 0 next edge; start with mode 6 -> 1 at index 0.
